modulo_pagamento_entrega: RTL and testbench
===========================================

// Module: modulo_pagamento_entrega
// PURPOSE
//   Payment/delivery responder for the vending-machine main controller. Consumes the controller's
//   2-bit estado (0 idle, 1 product check, 2 payment check, 3 delivery) and produces valor_correto
//   and tempo for it. Also accumulates coin credit, releases the product and computes change.
// PARAMETERS
//   VAL_W         8     width of coin value, price, credit and change (units of cents)
//   TEMPO_CICLOS  50    delivery duration in clk cycles; legal range 2..65535
//   INATIV_CICLOS 1000  idle cycles before auto-refund (only with DEVOLUCAO_INATIVIDADE_EN)
// PORTS
//   clk              in   1      system clock, rising edge
//   rst_n            in   1      asynchronous reset, active low
//   estado           in   2      controller state
//   moeda_valida     in   1      one-cycle strobe: coin inserted, value on moeda_valor
//   moeda_valor      in   VAL_W  value of inserted coin
//   preco            in   VAL_W  price of selected product; sampled every cycle
//   cancelar         in   1      one-cycle strobe: customer requests refund
//   valor_correto    out  1      registered: credito >= preco
//   tempo            out  1      one-cycle pulse: delivery finished
//   liberar_produto  out  1      one-cycle pulse: open product gate
//   credito          out  VAL_W  current accumulated credit
//   troco            out  VAL_W  change/refund amount; held until next troco_valido
//   troco_valido     out  1      one-cycle pulse: troco updated, dispense change
//   moeda_rejeitada  out  1      one-cycle pulse: coin refused
// BEHAVIOUR
//   Reset (async, rst_n=0): all outputs 0, credit 0, timer 0, estado_ant 0. Outputs are registered.
//   Coins: if moeda_valida and estado!=3, then credito <= sat(credito+moeda_valor).
//     Saturates at 2^VAL_W-1, and moeda_rejeitada pulses if the sum overflowed.
//     If moeda_valida and estado==3, the coin is refused: moeda_rejeitada=1, credit unchanged.
//   valor_correto <= (next credito >= preco) every cycle (1-cycle latency from the coin strobe).
//     It must be valid during the single cycle that estado==2.
//   Delivery entry: first cycle with estado==3 and estado_ant!=3 (estado_ant = estado delayed
//     one cycle). On that cycle:
//     - troco <= credito-preco; troco_valido=1; liberar_produto=1; credito <= 0; timer <= 1.
//     - If credito<preco at entry (illegal), then troco=0 and credit is cleared anyway.
//   While estado==3: timer increments each cycle. When timer==TEMPO_CICLOS-1, tempo=1 for one
//     cycle and timer returns to 0. tempo does not re-fire until a new entry.
//   Leaving 3 early (estado!=3 before tempo): timer cleared, no tempo pulse, no second release.
//   Payment refused (estado goes 2 -> 0): credit is kept, so the customer can add coins.
//   cancelar with estado in {0,1}: troco <= credito, troco_valido=1, credito <= 0.
//     If credito==0, no pulse. cancelar is ignored in estado 2 and 3.
//   Simultaneous coin and cancelar in estado 0/1: the refund includes the coin (credito+moeda).
//   Async reset mid-delivery: pending change and delivery are lost; outputs return to 0.
// CONFIGURATION
//   DEVOLUCAO_INATIVIDADE_EN defined: an inactivity counter runs while estado==0 and credito!=0.
//     The counter is cleared by any coin, by cancelar, or by estado!=0.
//     At INATIV_CICLOS cycles it acts as cancelar: troco=credito, troco_valido pulse, credito=0.
//   Not defined: no counter logic; credit is held indefinitely.
// TESTING
//   1. Reset with rst_n=0 mid-run -> all outputs 0 immediately, without waiting for clk.
//   2. preco=150; coins 100, 50 -> credito=150, valor_correto=1 one cycle after the 2nd coin.
//      Then estado=3 -> liberar_produto pulse, troco=0 with troco_valido, tempo pulse
//      TEMPO_CICLOS-1 cycles after entry.
//   3. preco=150; coins 100, 100; estado 2 then 3 -> troco=50 with troco_valido on the entry
//      cycle; credito=0.
//   4. preco=200; coin 100; estado 2 then 0 -> valor_correto=0, credito stays 100;
//      cancelar -> troco=100, credito=0.
//   5. credito=250, VAL_W=8, coin 10 -> credito=255, moeda_rejeitada=1.
//      Coin 5 during estado 3 -> moeda_rejeitada=1, credito unchanged.
//   6. DEVOLUCAO_INATIVIDADE_EN, INATIV_CICLOS=20, credito=50, estado=0 idle
//      -> troco_valido at cycle 20 with troco=50.
//      A coin at cycle 10 restarts the count. Without the macro, no refund after 100 cycles.

Source files
------------

// File: rtl/modulo_pagamento_entrega.sv
// Payment/delivery responder: coin credit, product release, change and delivery timing.
// Optional inactivity auto-refund enabled by defining DEVOLUCAO_INATIVIDADE_EN.
module modulo_pagamento_entrega #(
  parameter int VAL_W         = 8,
  parameter int TEMPO_CICLOS  = 50,
  parameter int INATIV_CICLOS = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       estado,
  input  logic             moeda_valida,
  input  logic [VAL_W-1:0] moeda_valor,
  input  logic [VAL_W-1:0] preco,
  input  logic             cancelar,
  output logic             valor_correto,
  output logic             tempo,
  output logic             liberar_produto,
  output logic [VAL_W-1:0] credito,
  output logic [VAL_W-1:0] troco,
  output logic             troco_valido,
  output logic             moeda_rejeitada
);

  localparam int TMR_W = 16;
  localparam logic [TMR_W-1:0] TEMPO_MAX = TMR_W'(TEMPO_CICLOS - 1);

  localparam logic [1:0] EST_IDLE    = 2'd0;
  localparam logic [1:0] EST_PRODUTO = 2'd1;
  localparam logic [1:0] EST_ENTREGA = 2'd3;

  function automatic logic [VAL_W-1:0] sat_add(input logic [VAL_W-1:0] a,
                                               input logic [VAL_W-1:0] b);
    logic [VAL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[VAL_W] ? {VAL_W{1'b1}} : s[VAL_W-1:0];
  endfunction

  function automatic logic add_ovf(input logic [VAL_W-1:0] a,
                                   input logic [VAL_W-1:0] b);
    logic [VAL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[VAL_W];
  endfunction

  // Change never goes negative: an underpaid delivery pays out nothing.
  function automatic logic [VAL_W-1:0] sub_floor(input logic [VAL_W-1:0] a,
                                                 input logic [VAL_W-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

  logic [1:0]       estado_ant;
  logic [TMR_W-1:0] timer;
  logic             entrada;
  logic             moeda_aceita;
  logic             cancel_ok;
  logic             devolver;
  logic             rejeita_nxt;
  logic             inativ_fim;
  logic [VAL_W-1:0] credito_moeda;
  logic [VAL_W-1:0] credito_nxt;

`ifdef DEVOLUCAO_INATIVIDADE_EN
  localparam int INA_W = $clog2(INATIV_CICLOS) + 1;
  localparam logic [INA_W-1:0] INATIV_MAX = INA_W'(INATIV_CICLOS - 1);

  logic [INA_W-1:0] inativ_cnt;
  logic             inativ_ativo;

  // Any customer action or leaving idle restarts the inactivity window.
  assign inativ_ativo = (estado == EST_IDLE) && (credito != '0) &&
                        !moeda_valida && !cancelar;
  assign inativ_fim   = inativ_ativo && (inativ_cnt == INATIV_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inativ_cnt <= '0;
    end else if (inativ_ativo && !inativ_fim) begin
      inativ_cnt <= inativ_cnt + INA_W'(1);
    end else begin
      inativ_cnt <= '0;
    end
  end
`else
  assign inativ_fim = 1'b0;
`endif

  always_comb begin
    entrada       = (estado == EST_ENTREGA) && (estado_ant != EST_ENTREGA);
    moeda_aceita  = moeda_valida && (estado != EST_ENTREGA);
    cancel_ok     = cancelar && ((estado == EST_IDLE) || (estado == EST_PRODUTO));
    devolver      = cancel_ok || inativ_fim;
    credito_moeda = moeda_aceita ? sat_add(credito, moeda_valor) : credito;
    rejeita_nxt   = moeda_valida && (!moeda_aceita || add_ovf(credito, moeda_valor));
    credito_nxt   = credito_moeda;
    if (entrada || devolver) begin
      credito_nxt = '0;
    end
  end

  // Credit, change and coin handling register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_ant      <= EST_IDLE;
      credito         <= '0;
      valor_correto   <= 1'b0;
      troco           <= '0;
      troco_valido    <= 1'b0;
      liberar_produto <= 1'b0;
      moeda_rejeitada <= 1'b0;
    end else begin
      estado_ant      <= estado;
      credito         <= credito_nxt;
      valor_correto   <= (credito_nxt >= preco);
      moeda_rejeitada <= rejeita_nxt;
      liberar_produto <= entrada;
      troco_valido    <= 1'b0;
      if (entrada) begin
        troco        <= sub_floor(credito, preco);
        troco_valido <= 1'b1;
      end else if (devolver && (credito_moeda != '0)) begin
        troco        <= credito_moeda;
        troco_valido <= 1'b1;
      end
    end
  end

  // Delivery timer stage: zero means idle, so tempo fires once per entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      tempo <= 1'b0;
    end else begin
      tempo <= 1'b0;
      if (entrada) begin
        timer <= TMR_W'(1);
      end else if ((estado == EST_ENTREGA) && (timer != '0)) begin
        if (timer == TEMPO_MAX) begin
          timer <= '0;
          tempo <= 1'b1;
        end else begin
          timer <= timer + TMR_W'(1);
        end
      end else begin
        timer <= '0;
      end
    end
  end

endmodule

// File: tb/tb_modulo_pagamento_entrega.sv
// Randomized bench for modulo_pagamento_entrega against a cycle-level behavioural model.
module tb_modulo_pagamento_entrega;

  localparam int VAL_W  = 8;
  localparam int TEMPO  = 12;
  localparam int INATIV = 20;
  localparam int MAXV   = (1 << VAL_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       estado;
  logic             moeda_valida;
  logic [VAL_W-1:0] moeda_valor;
  logic [VAL_W-1:0] preco;
  logic             cancelar;
  logic             valor_correto;
  logic             tempo;
  logic             liberar_produto;
  logic [VAL_W-1:0] credito;
  logic [VAL_W-1:0] troco;
  logic             troco_valido;
  logic             moeda_rejeitada;

  modulo_pagamento_entrega #(
    .VAL_W(VAL_W), .TEMPO_CICLOS(TEMPO), .INATIV_CICLOS(INATIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .estado(estado), .moeda_valida(moeda_valida),
    .moeda_valor(moeda_valor), .preco(preco), .cancelar(cancelar),
    .valor_correto(valor_correto), .tempo(tempo), .liberar_produto(liberar_produto),
    .credito(credito), .troco(troco), .troco_valido(troco_valido),
    .moeda_rejeitada(moeda_rejeitada)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int m_cred, m_troco, m_prev, m_left, m_idle;
  bit m_vc, m_tempo, m_lib, m_tv, m_rej;
  int n_tempo, n_tv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cred = 0; m_troco = 0; m_prev = 0; m_left = 0; m_idle = 0;
    m_vc = 0; m_tempo = 0; m_lib = 0; m_tv = 0; m_rej = 0;
  endtask

  task automatic model_cycle(input int est, input bit mv, input int mval,
                             input bit canc, input int pr);
    int c, s;
    bit entry;
    entry = (est == 3) && (m_prev != 3);
    m_rej = 0; m_lib = 0; m_tv = 0; m_tempo = 0;
    c = m_cred;
    if (mv) begin
      if (est == 3) m_rej = 1;
      else begin
        s = m_cred + mval;
        if (s > MAXV) begin s = MAXV; m_rej = 1; end
        c = s;
      end
    end
    if (est == 3) begin
      m_idle = 0;
      if (entry) begin
        m_troco = (m_cred >= pr) ? m_cred - pr : 0;
        m_tv = 1; m_lib = 1; c = 0;
        m_left = TEMPO - 1;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_tempo = 1;
      end
    end else begin
      m_left = 0;
      if (canc && est <= 1) begin
        if (c != 0) begin m_troco = c; m_tv = 1; end
        c = 0;
      end
`ifdef DEVOLUCAO_INATIVIDADE_EN
      if (est == 0 && m_cred != 0 && !mv && !canc) begin
        m_idle++;
        if (m_idle == INATIV) begin
          m_troco = m_cred; m_tv = 1; c = 0; m_idle = 0;
        end
      end else m_idle = 0;
`endif
    end
    m_cred = c;
    m_vc = (c >= pr);
    m_prev = est;
  endtask

  task automatic compare_all();
    chk("credito", credito, m_cred);
    chk("valor_correto", valor_correto, m_vc);
    chk("tempo", tempo, m_tempo);
    chk("liberar_produto", liberar_produto, m_lib);
    chk("troco_valido", troco_valido, m_tv);
    chk("troco", troco, m_troco);
    chk("moeda_rejeitada", moeda_rejeitada, m_rej);
  endtask

  task automatic step(input int est, input bit mv, input int mval, input bit canc);
    estado = est[1:0]; moeda_valida = mv; moeda_valor = mval[VAL_W-1:0]; cancelar = canc;
    @(posedge clk);
    model_cycle(est, mv, mval, canc, int'(preco));
    #1;
    compare_all();
    if (tempo) n_tempo++;
    if (troco_valido) n_tv++;
  endtask

  task automatic reset_all_zero(input string tag);
    chk({tag, "_cred"}, credito, 0);
    chk({tag, "_vc"}, valor_correto, 0);
    chk({tag, "_tempo"}, tempo, 0);
    chk({tag, "_lib"}, liberar_produto, 0);
    chk({tag, "_troco"}, troco, 0);
    chk({tag, "_tv"}, troco_valido, 0);
    chk({tag, "_rej"}, moeda_rejeitada, 0);
  endtask

  initial begin
    int hold, est_r, t0;
    rst_n = 1'b0; estado = 0; moeda_valida = 0; moeda_valor = 0; preco = 0; cancelar = 0;
    n_tempo = 0; n_tv = 0;
    model_reset();
    #12;
    reset_all_zero("reset");
    rst_n = 1'b1;

    // Exact payment, delivery and tempo timing
    preco = 150;
    step(0, 1, 100, 0);
    step(0, 1, 50, 0);
    chk("t2_cred", credito, 150);
    chk("t2_vc", valor_correto, 1);
    step(2, 0, 0, 0);
    step(3, 0, 0, 0);
    chk("t2_lib", liberar_produto, 1);
    chk("t2_troco", troco, 0);
    chk("t2_tv", troco_valido, 1);
    t0 = n_tempo;
    for (int i = 0; i < TEMPO - 2; i++) step(3, 0, 0, 0);
    chk("t2_tempo_early", n_tempo - t0, 0);
    step(3, 0, 0, 0);
    chk("t2_tempo", tempo, 1);
    for (int i = 0; i < 5; i++) step(3, 0, 0, 0);
    chk("t2_tempo_once", n_tempo - t0, 1);
    step(0, 0, 0, 0);

    // Overpayment gives change
    step(0, 1, 100, 0);
    step(1, 1, 100, 0);
    step(2, 0, 0, 0);
    step(3, 0, 0, 0);
    chk("t3_troco", troco, 50);
    chk("t3_cred", credito, 0);
    step(0, 0, 0, 0);

    // Refused payment keeps credit; cancel refunds it
    preco = 200;
    step(0, 1, 100, 0);
    step(2, 0, 0, 0);
    chk("t4_vc", valor_correto, 0);
    step(0, 0, 0, 0);
    chk("t4_cred", credito, 100);
    step(0, 0, 0, 1);
    chk("t4_troco", troco, 100);
    chk("t4_cred0", credito, 0);

    // Saturation, and coin refused during delivery
    step(0, 1, 200, 0);
    step(0, 1, 50, 0);
    step(0, 1, 10, 0);
    chk("t5_sat", credito, 255);
    chk("t5_rej", moeda_rejeitada, 1);
    step(3, 0, 0, 0);
    step(3, 1, 5, 0);
    chk("t5_rej3", moeda_rejeitada, 1);
    chk("t5_cred3", credito, 0);
    step(0, 0, 0, 0);

    // Cancel together with a coin includes the coin
    step(1, 1, 30, 0);
    step(1, 1, 20, 1);
    chk("cancel_coin", troco, 50);

    // Idle credit: refunded only when the inactivity feature is built in
    preco = 100;
    step(0, 1, 50, 0);
    t0 = n_tv;
    for (int i = 0; i < 100; i++) step(0, (i == 9), 0, 0);
`ifdef DEVOLUCAO_INATIVIDADE_EN
    chk("inativ_refund", n_tv - t0, 1);
`else
    chk("no_inativ", n_tv - t0, 0);
    chk("no_inativ_cred", credito, 50);
`endif

    // Async reset mid-delivery, without a clock edge
    step(0, 1, 90, 0);
    step(3, 0, 0, 0);
    step(3, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    reset_all_zero("async");
    model_reset();
    #2 rst_n = 1'b1;

    // Randomized controller-like traffic
    hold = 0; est_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        est_r = $urandom_range(0, 3);
        hold = $urandom_range(1, TEMPO + 4);
      end
      hold--;
      if ($urandom_range(0, 15) == 0) preco = VAL_W'($urandom_range(0, MAXV));
      step(est_r, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) != 0) ? $urandom_range(1, 100) : $urandom_range(0, MAXV),
           ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
